// File: rtl/snn_neuron_pkg.sv
// Shared types and arithmetic helpers for the LIF membrane-potential engine.
// Helpers work on a 32-bit signed carrier; callers narrow the result to their width.
package snn_neuron_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LEAK  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    OP_EVENT = 1'b0,
    OP_LEAK  = 1'b1
  } op_e;

  localparam int CALC_W = 32;

  // Adds two sign-extended values and clamps the sum to the signed range of 'width' bits.
  function automatic logic signed [CALC_W-1:0] sat_add(
    input logic signed [CALC_W-1:0] a,
    input logic signed [CALC_W-1:0] b,
    input int                       width
  );
    logic signed [CALC_W:0] sum;
    logic signed [CALC_W:0] hi;
    logic signed [CALC_W:0] lo;
    logic        [CALC_W:0] one;
    one = (CALC_W+1)'(1);
    sum = {a[CALC_W-1], a} + {b[CALC_W-1], b};
    hi  = $signed((one << (width - 1)) - one);
    lo  = ~hi;
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return CALC_W'(sum);
  endfunction

  function automatic logic signed [CALC_W-1:0] leak(
    input logic signed [CALC_W-1:0] v,
    input int                       shift
  );
    return v - (v >>> shift);
  endfunction

endpackage

// File: rtl/snn_spike_fifo.sv
// Synchronous first-word-fall-through FIFO holding addresses of neurons that fired.
// DEPTH must be a power of two; pushes while full are dropped unless a pop frees a slot.
module snn_spike_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full || do_pop);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lif_neuron_update.sv
// Two-stage read-modify-write engine for LIF membrane potentials in a dual-port BRAM.
// Optional spike statistics output is enabled by defining SPIKE_COUNT_EN.
//   state | meaning
//   RUN   | accept weighted events or a timestep request
//   LEAK  | issue one leak read per cycle across every neuron
//   DRAIN | last leak write retires, then step_done pulses
module lif_neuron_update
  import snn_neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int THRESHOLD  = 1024,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 4,
  parameter int SPK_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ev_valid_i,
  output logic                  ev_ready_o,
  input  logic [ADDR_WIDTH-1:0] ev_addr_i,
  input  logic [DATA_WIDTH-1:0] ev_weight_i,
  input  logic                  step_valid_i,
  output logic                  step_ready_o,
  output logic                  step_done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  spk_valid_o,
  input  logic                  spk_ready_i,
  output logic [ADDR_WIDTH-1:0] spk_addr_o,
  output logic                  busy_o
`ifdef SPIKE_COUNT_EN
  ,
  output logic [31:0]           spk_count_o
`endif
);

  localparam int CNT_W = $clog2(SPK_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0]        LAST_ADDR  = '1;
  localparam logic signed [DATA_WIDTH-1:0] THRESH_V   = DATA_WIDTH'(THRESHOLD);
  localparam logic signed [DATA_WIDTH-1:0] RESET_V    = DATA_WIDTH'(V_RESET);
  localparam logic [CNT_W-1:0]             EV_MAX_CNT = CNT_W'(SPK_DEPTH - 2);

  state_e                        state_q;
  logic [ADDR_WIDTH-1:0]         sweep_cnt_q;
  logic                          step_done_q;

  logic                          u_valid_q;
  op_e                           u_op_q;
  logic [ADDR_WIDTH-1:0]         u_addr_q;
  logic signed [DATA_WIDTH-1:0]  u_weight_q;

  logic                          fwd_valid_q;
  logic [ADDR_WIDTH-1:0]         fwd_addr_q;
  logic signed [DATA_WIDTH-1:0]  fwd_data_q;

  logic                          ev_fire;
  logic                          step_fire;
  logic                          leak_issue;
  logic signed [DATA_WIDTH-1:0]  operand;
  logic signed [CALC_W-1:0]      op_ext;
  logic signed [DATA_WIDTH-1:0]  sum_v;
  logic signed [DATA_WIDTH-1:0]  leak_v;
  logic signed [DATA_WIDTH-1:0]  wr_val;
  logic                          fire;
  logic                          spk_pop;
  logic                          fifo_empty;
  logic [CNT_W-1:0]              fifo_count;

  // One FIFO slot stays reserved for whatever op is currently in U.
  assign ev_ready_o   = (state_q == RUN) && (fifo_count <= EV_MAX_CNT);
  assign step_ready_o = (state_q == RUN) && !u_valid_q && !ev_valid_i;
  assign ev_fire      = ev_valid_i && ev_ready_o;
  assign step_fire    = step_valid_i && step_ready_o;
  assign leak_issue   = (state_q == LEAK);

  assign rd_en_o      = ev_fire || leak_issue;
  assign rd_addr_o    = leak_issue ? sweep_cnt_q : ev_addr_i;

  // BRAM is read-first, so the previous cycle's write must be forwarded.
  always_comb begin
    operand = rd_data_i;
    if (fwd_valid_q && (fwd_addr_q == u_addr_q)) begin
      operand = fwd_data_q;
    end
    op_ext = CALC_W'(operand);
    sum_v  = DATA_WIDTH'(sat_add(op_ext, CALC_W'(u_weight_q), DATA_WIDTH));
    leak_v = DATA_WIDTH'(leak(op_ext, LEAK_SHIFT));
    fire   = u_valid_q && (u_op_q == OP_EVENT) && (sum_v >= THRESH_V);
    if (u_op_q == OP_LEAK) begin
      wr_val = leak_v;
    end else if (fire) begin
      wr_val = RESET_V;
    end else begin
      wr_val = sum_v;
    end
  end

  assign wr_en_o     = u_valid_q;
  assign wr_addr_o   = u_addr_q;
  assign wr_data_o   = wr_val;
  assign step_done_o = step_done_q;
  assign busy_o      = (state_q != RUN) || u_valid_q;
  assign spk_valid_o = !fifo_empty;
  assign spk_pop     = spk_valid_o && spk_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      sweep_cnt_q <= '0;
      step_done_q <= 1'b0;
      u_valid_q   <= 1'b0;
      u_op_q      <= OP_EVENT;
      u_addr_q    <= '0;
      u_weight_q  <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      u_valid_q <= rd_en_o;
      if (rd_en_o) begin
        u_op_q     <= leak_issue ? OP_LEAK : OP_EVENT;
        u_addr_q   <= rd_addr_o;
        u_weight_q <= ev_weight_i;
      end
      if (u_valid_q) begin
        fwd_valid_q <= 1'b1;
        fwd_addr_q  <= u_addr_q;
        fwd_data_q  <= wr_val;
      end
      step_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (step_fire) begin
            state_q     <= LEAK;
            sweep_cnt_q <= '0;
          end
        end
        LEAK: begin
          if (sweep_cnt_q == LAST_ADDR) begin
            state_q     <= DRAIN;
            sweep_cnt_q <= '0;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Nothing issues here, so U is empty on the edge that leaves DRAIN.
          state_q     <= RUN;
          step_done_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  snn_spike_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (SPK_DEPTH)
  ) u_spk_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (fire),
    .push_data_i (u_addr_q),
    .pop_i       (spk_pop),
    .pop_data_o  (spk_addr_o),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef SPIKE_COUNT_EN
  logic [31:0] spk_count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      spk_count_q <= '0;
    end else if (step_done_q) begin
      spk_count_q <= {31'd0, fire};
    end else if (fire && (spk_count_q != '1)) begin
      spk_count_q <= spk_count_q + 32'd1;
    end
  end

  assign spk_count_o = spk_count_q;
`else
  // Without spike statistics the engine carries no counter.
`endif

endmodule

// File: tb/tb_lif_neuron_update.sv
// Directed bench for lif_neuron_update with a read-first BRAM model and write/spike logs.
module tb_lif_neuron_update;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ev_valid = 1'b0;
  logic               ev_ready;
  logic [9:0]         ev_addr = '0;
  logic signed [15:0] ev_weight = '0;
  logic               step_valid = 1'b0;
  logic               step_ready;
  logic               step_done;
  logic               rd_en;
  logic [9:0]         rd_addr;
  logic signed [15:0] rd_data = '0;
  logic               wr_en;
  logic [9:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               spk_valid;
  logic               spk_ready = 1'b1;
  logic [9:0]         spk_addr;
  logic               busy;

  logic               pre_en = 1'b0;
  logic [9:0]         pre_addr = '0;
  logic signed [15:0] pre_data = '0;
  logic signed [15:0] mem [1024] = '{default: 16'sd0};

  logic signed [15:0] wr_log_d [$];
  logic [9:0]         wr_log_a [$];
  logic [9:0]         spk_log  [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lif_neuron_update dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ev_valid_i   (ev_valid),
    .ev_ready_o   (ev_ready),
    .ev_addr_i    (ev_addr),
    .ev_weight_i  (ev_weight),
    .step_valid_i (step_valid),
    .step_ready_o (step_ready),
    .step_done_o  (step_done),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .spk_valid_o  (spk_valid),
    .spk_ready_i  (spk_ready),
    .spk_addr_o   (spk_addr),
    .busy_o       (busy)
  );

  // Read-first dual-port BRAM; preload port borrows port B when the DUT is idle.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_log_a.push_back(wr_addr);
      wr_log_d.push_back(wr_data);
    end
    if (rst_n && spk_valid && spk_ready) spk_log.push_back(spk_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log_a.delete();
    wr_log_d.delete();
    spk_log.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic signed [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle after the handshake (the U cycle).
  task automatic send_ev(input logic [9:0] a, input logic signed [15:0] w);
    int guard;
    guard = 0;
    ev_valid = 1'b1; ev_addr = a; ev_weight = w;
    @(negedge clk);
    while (!ev_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ev_ready) chk("ev_ready_wait", ev_ready, 1);
    @(posedge clk); #1;
    ev_valid = 1'b0;
  endtask

  task automatic run_step(output int k, output int evr);
    step_valid = 1'b1;
    @(negedge clk);
    chk("step_ready", step_ready, 1);
    @(posedge clk); #1;
    step_valid = 1'b0;
    k = 0; evr = 0;
    while (k < 1500) begin
      @(negedge clk);
      k++;
      if (step_done) break;
      if (ev_ready) evr++;
    end
  endtask

  initial begin
    int k, evr, g;

    // Reset values
    cycles(3);
    @(negedge clk);
    chk("rst_ev_ready", ev_ready, 1);
    chk("rst_step_ready", step_ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_spk_addr", spk_addr, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);

    preload(10'd5, 16'sd1000);
    preload(10'd3, 16'sd32700);
    preload(10'd4, -16'sd32700);
    preload(10'd0, 16'sd160);
    preload(10'd1, -16'sd160);

    // Event crossing threshold: write V_RESET at t+1, spike visible at t+2
    clear_logs();
    send_ev(10'd5, 16'sd30);
    @(negedge clk);
    chk("ev5_wr_en", wr_en, 1);
    chk("ev5_wr_addr", wr_addr, 5);
    chk("ev5_wr_data", wr_data, 0);
    chk("ev5_spk_early", spk_valid, 0);
    @(negedge clk);
    chk("ev5_spk_valid", spk_valid, 1);
    chk("ev5_spk_addr", spk_addr, 5);
    cycles(3);
    chk("ev5_mem", mem[5], 0);

    // Back-to-back same address, relies on forwarding
    clear_logs();
    send_ev(10'd7, 16'sd100);
    send_ev(10'd7, 16'sd100);
    send_ev(10'd7, 16'sd100);
    cycles(4);
    chk("b2b_nwr", wr_log_d.size(), 3);
    chk("b2b_wr0", wr_log_d[0], 100);
    chk("b2b_wr1", wr_log_d[1], 200);
    chk("b2b_wr2", wr_log_d[2], 300);
    chk("b2b_nspk", spk_log.size(), 0);
    chk("b2b_mem", mem[7], 300);

    // Positive saturation fires, negative saturation clamps
    clear_logs();
    send_ev(10'd3, 16'sd200);
    cycles(4);
    chk("satp_nspk", spk_log.size(), 1);
    chk("satp_spk", spk_log[0], 3);
    chk("satp_mem", mem[3], 0);
    clear_logs();
    send_ev(10'd4, -16'sd200);
    cycles(4);
    chk("satn_wr", wr_log_d[0], -32768);
    chk("satn_nspk", spk_log.size(), 0);
    chk("satn_mem", mem[4], -32768);

    // Backpressure on spike FIFO
    clear_logs();
    spk_ready = 1'b0;
    send_ev(10'd10, 16'sd2000);
    send_ev(10'd11, 16'sd2000);
    send_ev(10'd12, 16'sd2000);
    send_ev(10'd13, 16'sd2000);
    @(negedge clk);
    chk("bp_ev_ready_3", ev_ready, 0);
    chk("bp_spk_valid", spk_valid, 1);
    chk("bp_spk_head", spk_addr, 10);
    @(negedge clk);
    chk("bp_ev_ready_4", ev_ready, 0);
    @(posedge clk); #1;
    spk_ready = 1'b1;
    cycles(6);
    @(negedge clk);
    chk("bp_ev_ready_back", ev_ready, 1);
    chk("bp_nspk", spk_log.size(), 4);
    chk("bp_spk0", spk_log[0], 10);
    chk("bp_spk1", spk_log[1], 11);
    chk("bp_spk2", spk_log[2], 12);
    chk("bp_spk3", spk_log[3], 13);
    chk("bp_mem13", mem[13], 0);
    @(posedge clk); #1;

    // Leak sweep
    run_step(k, evr);
    chk("step_latency", k, 1026);
    chk("step_ev_ready_low", evr, 0);
    @(negedge clk);
    chk("step_done_pulse", step_done, 0);
    chk("leak_mem0", mem[0], 150);
    chk("leak_mem1", mem[1], -150);
    chk("leak_mem7", mem[7], 282);
    chk("leak_mem4", mem[4], -30720);
    @(posedge clk); #1;

    // Reset mid-sweep
    preload(10'd98, 16'sd480);
    preload(10'd100, 16'sd160);
    preload(10'd101, 16'sd320);
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    g = 0;
    while (!(rd_en && rd_addr == 10'd100) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("mid_reached_100", rd_addr, 100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_ev_ready", ev_ready, 1);
    chk("mid_rst_step_ready", step_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step_done", step_done, 0);
    cycles(3);
    chk("mid_mem98", mem[98], 450);
    chk("mid_mem100", mem[100], 160);
    chk("mid_mem101", mem[101], 320);
    rst_n = 1'b1;
    cycles(2);
    run_step(k, evr);
    chk("step2_latency", k, 1026);
    chk("step2_ev_ready_low", evr, 0);
    cycles(2);
    chk("step2_mem98", mem[98], 422);
    chk("step2_mem100", mem[100], 150);
    chk("step2_mem101", mem[101], 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
